// File: rtl/systolic_mm_engine_if.sv
// Bundle of control, operand and result signals for the systolic matrix engine.
//
// Handshake: the master raises start (with accum, a_flat, b_flat valid in the
// same cycle). The engine accepts it only while busy is low. It then ignores
// start and its operands until it returns to idle. done pulses for exactly one
// cycle when c_flat is updated. c_valid stays high from that pulse until the
// next accepted start.
interface systolic_mm_engine_if #(
  parameter int WIDTH     = 4,
  parameter int WIDTH_SUM = 8,
  parameter int N         = 3
);
  logic                       enable;
  logic                       start;
  logic                       accum;
  logic [N*N*WIDTH-1:0]       a_flat;
  logic [N*N*WIDTH-1:0]       b_flat;
  logic [N*N*WIDTH_SUM-1:0]   c_flat;
  logic                       busy;
  logic                       done;
  logic                       c_valid;
  logic                       multi_over;

  modport master (
    output enable, start, accum, a_flat, b_flat,
    input  c_flat, busy, done, c_valid, multi_over
  );

  modport slave (
    input  enable, start, accum, a_flat, b_flat,
    output c_flat, busy, done, c_valid, multi_over
  );
endinterface

// File: rtl/systolic_mm_engine.sv
// N x N output-stationary systolic array computing C = A * B (or C += A * B).
// Operands enter skewed from the left and top edges. Each PE multiplies the
// pair passing through it and accumulates in place. The result register is
// loaded once, on the last compute edge.
module systolic_mm_engine #(
  parameter int WIDTH     = 4,
  parameter int WIDTH_SUM = 8,
  parameter int N         = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  systolic_mm_engine_if.slave  bus,
  output logic [1:0]           dbg_state
);

  localparam int TW = $clog2(3*N);
  localparam logic [TW-1:0] T_LAST = TW'(3*N-3);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE_S  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [TW-1:0]            t;
  logic [N*N*WIDTH-1:0]     a_reg;
  logic [N*N*WIDTH-1:0]     b_reg;
  logic [WIDTH-1:0]         a_pipe   [N][N];
  logic [WIDTH-1:0]         b_pipe   [N][N];
  logic [WIDTH-1:0]         a_in     [N][N];
  logic [WIDTH-1:0]         b_in     [N][N];
  logic [2*WIDTH-1:0]       prod_w   [N][N];
  logic [WIDTH_SUM:0]       sum_w    [N][N];
  logic [WIDTH_SUM-1:0]     acc      [N][N];
  logic [WIDTH_SUM-1:0]     acc_next [N][N];
  logic                     carry_any;
  logic [N*N*WIDTH_SUM-1:0] c_reg;
  logic                     c_valid_reg;
  logic                     over_reg;

  // State register; an asynchronous reset abandons any run in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic: a stalled compute step (enable low) never finishes the run
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = COMPUTE;
      COMPUTE: if (bus.enable && (t == T_LAST)) state_next = DONE_S;
      DONE_S:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // PE operand inputs: the skewed edge feed for row/column 0, the neighbour's
  // registered operand everywhere else
  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        a_in[i][j] = '0;
        b_in[i][j] = '0;
      end
    end
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) begin
        if (int'(t) == i + k) a_in[i][0] = a_reg[(i*N+k)*WIDTH +: WIDTH];
      end
    end
    for (int j = 0; j < N; j++) begin
      for (int k = 0; k < N; k++) begin
        if (int'(t) == j + k) b_in[0][j] = b_reg[(k*N+j)*WIDTH +: WIDTH];
      end
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 1; j < N; j++) a_in[i][j] = a_pipe[i][j-1];
    end
    for (int i = 1; i < N; i++) begin
      for (int j = 0; j < N; j++) b_in[i][j] = b_pipe[i-1][j];
    end
  end

  // Multiply-accumulate for every PE; the extra sum bit is the carry-out
  always_comb begin
    carry_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        prod_w[i][j]   = {{WIDTH{1'b0}}, a_in[i][j]} * {{WIDTH{1'b0}}, b_in[i][j]};
        sum_w[i][j]    = {1'b0, acc[i][j]}
                       + {{(WIDTH_SUM+1-2*WIDTH){1'b0}}, prod_w[i][j]};
        acc_next[i][j] = sum_w[i][j][WIDTH_SUM-1:0];
        carry_any      = carry_any | sum_w[i][j][WIDTH_SUM];
      end
    end
  end

  // Datapath: operand capture on start, enabled compute steps, result load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t           <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      c_reg       <= '0;
      c_valid_reg <= 1'b0;
      over_reg    <= 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_pipe[i][j] <= '0;
          b_pipe[i][j] <= '0;
          acc[i][j]    <= '0;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg       <= bus.a_flat;
            b_reg       <= bus.b_flat;
            t           <= '0;
            c_valid_reg <= 1'b0;
            if (!bus.accum) over_reg <= 1'b0;
            for (int i = 0; i < N; i++) begin
              for (int j = 0; j < N; j++) begin
                a_pipe[i][j] <= '0;
                b_pipe[i][j] <= '0;
                if (!bus.accum) acc[i][j] <= '0;
              end
            end
          end
        end
        COMPUTE: begin
          if (bus.enable) begin
            t        <= t + 1'b1;
            over_reg <= over_reg | carry_any;
            for (int i = 0; i < N; i++) begin
              for (int j = 0; j < N; j++) begin
                a_pipe[i][j] <= a_in[i][j];
                b_pipe[i][j] <= b_in[i][j];
                acc[i][j]    <= acc_next[i][j];
              end
            end
            if (t == T_LAST) begin
              c_valid_reg <= 1'b1;
              for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                  c_reg[(i*N+j)*WIDTH_SUM +: WIDTH_SUM] <= acc_next[i][j];
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.c_flat     = c_reg;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE_S);
  assign bus.c_valid    = c_valid_reg;
  assign bus.multi_over = over_reg;
  assign dbg_state      = state;

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Directed bench for systolic_mm_engine: a table of full runs plus hand-written
// sequences for stall, busy-start, mid-run reset and an N=4 build.
module tb_systolic_mm_engine;

  localparam int WIDTH     = 4;
  localparam int WIDTH_SUM = 8;
  localparam int N         = 3;
  localparam int N4        = 4;
  localparam int AW        = N*N*WIDTH;
  localparam int CW        = N*N*WIDTH_SUM;
  localparam int LIMIT     = 40;

  typedef struct {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic          accum;
    logic [CW-1:0] c;
    logic          over;
  } vec_t;

  localparam logic [AW-1:0] A_ID  = {4'd1, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd1};
  localparam logic [AW-1:0] M19   = {4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
  localparam logic [AW-1:0] ALL_F = {9{4'hF}};
  localparam logic [CW-1:0] C19   = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
  localparam logic [CW-1:0] C2X   = {8'd18, 8'd16, 8'd14, 8'd12, 8'd10, 8'd8, 8'd6, 8'd4, 8'd2};
  localparam logic [CW-1:0] C163  = {9{8'd163}};
  localparam logic [CW-1:0] C164  = {8'd172, 8'd171, 8'd170, 8'd169, 8'd168,
                                     8'd167, 8'd166, 8'd165, 8'd164};
  localparam logic [CW-1:0] CMM   = {8'd150, 8'd126, 8'd102, 8'd96, 8'd81,
                                     8'd66, 8'd42, 8'd36, 8'd30};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] dbg_state;
  logic [1:0] dbg_state4;

  systolic_mm_engine_if #(.WIDTH(WIDTH), .WIDTH_SUM(WIDTH_SUM), .N(N))  bus ();
  systolic_mm_engine_if #(.WIDTH(WIDTH), .WIDTH_SUM(WIDTH_SUM), .N(N4)) bus4 ();

  systolic_mm_engine #(.WIDTH(WIDTH), .WIDTH_SUM(WIDTH_SUM), .N(N)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  systolic_mm_engine #(.WIDTH(WIDTH), .WIDTH_SUM(WIDTH_SUM), .N(N4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .dbg_state(dbg_state4)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [WIDTH_SUM-1:0] exp_q[$];
  logic [CW-1:0] last_c;
  vec_t vecs[6];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push_expected(input logic [CW-1:0] c);
    for (int k = 0; k < N*N; k++) exp_q.push_back(c[k*WIDTH_SUM +: WIDTH_SUM]);
  endtask

  task automatic compare_c(input string tag);
    logic [WIDTH_SUM-1:0] e;
    for (int k = 0; k < N*N; k++) begin
      e = exp_q.pop_front();
      check($sformatf("%s c[%0d]", tag, k), bus.c_flat[k*WIDTH_SUM +: WIDTH_SUM], e);
    end
  endtask

  // Count negedges until done is seen, starting from the negedge after the accept edge
  task automatic wait_done(inout int lat);
    while (bus.done !== 1'b1 && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_start(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic accum);
    bus.a_flat = a;
    bus.b_flat = b;
    bus.accum  = accum;
    bus.start  = 1'b1;
    @(negedge clk);
    // scramble inputs after acceptance: the run must use the captured copy
    bus.start  = 1'b0;
    bus.a_flat = ~a;
    bus.b_flat = ~b;
    bus.accum  = ~accum;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int lat;
    @(negedge clk);
    drive_start(v.a, v.b, v.accum);
    check({tag, " busy"}, bus.busy, 1'b1);
    check({tag, " c_valid low"}, bus.c_valid, 1'b0);
    check({tag, " c_flat hold"}, bus.c_flat, last_c);
    push_expected(v.c);
    lat = 0;
    wait_done(lat);
    check({tag, " latency"}, lat, 7);
    compare_c(tag);
    check({tag, " multi_over"}, bus.multi_over, v.over);
    check({tag, " c_valid"}, bus.c_valid, 1'b1);
    @(negedge clk);
    check({tag, " done pulse"}, bus.done, 1'b0);
    check({tag, " idle"}, bus.busy, 1'b0);
    check({tag, " c_valid kept"}, bus.c_valid, 1'b1);
    last_c = v.c;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lat;
    bus.enable  = 1'b1;
    bus.start   = 1'b0;
    bus.accum   = 1'b0;
    bus.a_flat  = '0;
    bus.b_flat  = '0;
    bus4.enable = 1'b1;
    bus4.start  = 1'b0;
    bus4.accum  = 1'b0;
    bus4.a_flat = '0;
    bus4.b_flat = '0;
    last_c      = '0;

    vecs[0] = '{A_ID,  M19,   1'b0, C19,  1'b0};
    vecs[1] = '{A_ID,  M19,   1'b1, C2X,  1'b0};
    vecs[2] = '{ALL_F, ALL_F, 1'b0, C163, 1'b1};
    vecs[3] = '{A_ID,  M19,   1'b1, C164, 1'b1};
    vecs[4] = '{A_ID,  M19,   1'b0, C19,  1'b0};
    vecs[5] = '{M19,   M19,   1'b0, CMM,  1'b0};

    // reset state
    repeat (3) @(negedge clk);
    check("rst c_flat", bus.c_flat, '0);
    check("rst busy", bus.busy, 1'b0);
    check("rst done", bus.done, 1'b0);
    check("rst c_valid", bus.c_valid, 1'b0);
    check("rst multi_over", bus.multi_over, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // stall for two cycles at t=3, with a start pulse that must be ignored
    @(negedge clk);
    drive_start(A_ID, M19, 1'b0);
    lat = 0;
    repeat (3) begin
      @(negedge clk);
      lat++;
    end
    bus.enable = 1'b0;
    bus.start  = 1'b1;
    bus.accum  = 1'b0;
    bus.a_flat = ALL_F;
    bus.b_flat = ALL_F;
    repeat (2) begin
      @(negedge clk);
      lat++;
      check("stall busy", bus.busy, 1'b1);
      check("stall state", dbg_state, 2'd1);
    end
    bus.enable = 1'b1;
    bus.start  = 1'b0;
    push_expected(C19);
    wait_done(lat);
    check("stall latency", lat, 9);
    compare_c("stall");
    check("stall multi_over", bus.multi_over, 1'b0);
    @(negedge clk);
    check("stall done pulse", bus.done, 1'b0);
    last_c = C19;

    // leave overflow set, then reset in the middle of an accumulate run
    run_vec("ovf", vecs[2]);
    @(negedge clk);
    drive_start(A_ID, M19, 1'b1);
    lat = 0;
    repeat (4) begin
      @(negedge clk);
      lat++;
    end
    check("mid busy", bus.busy, 1'b1);
    check("mid multi_over sticky", bus.multi_over, 1'b1);
    check("mid c_flat hold", bus.c_flat, C163);
    rst = 1'b0;
    #1;
    check("async c_flat", bus.c_flat, '0);
    check("async busy", bus.busy, 1'b0);
    check("async done", bus.done, 1'b0);
    check("async c_valid", bus.c_valid, 1'b0);
    check("async multi_over", bus.multi_over, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("in reset no done", bus.done, 1'b0);
    end

    // first start accepted on the first edge after reset release
    rst = 1'b1;
    drive_start(A_ID, M19, 1'b0);
    check("post-rst accepted", bus.busy, 1'b1);
    push_expected(C19);
    lat = 0;
    wait_done(lat);
    check("post-rst latency", lat, 7);
    compare_c("post-rst");
    check("post-rst multi_over", bus.multi_over, 1'b0);
    @(negedge clk);

    // N=4 build: all-ones times all-twos
    bus4.a_flat = {16{4'd1}};
    bus4.b_flat = {16{4'd2}};
    bus4.accum  = 1'b0;
    bus4.start  = 1'b1;
    @(negedge clk);
    bus4.start  = 1'b0;
    for (int k = 0; k < N4*N4; k++) exp_q.push_back(8'd8);
    lat = 0;
    while (bus4.done !== 1'b1 && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
    check("n4 latency", lat, 10);
    for (int k = 0; k < N4*N4; k++) begin
      logic [WIDTH_SUM-1:0] e;
      e = exp_q.pop_front();
      check($sformatf("n4 c[%0d]", k), bus4.c_flat[k*WIDTH_SUM +: WIDTH_SUM], e);
    end
    check("n4 multi_over", bus4.multi_over, 1'b0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/systolic_mm_engine.md
SYSTOLIC_MM_ENGINE -- requirements
Module: systolic_mm_engine

Interface
REQ-001 Parameter WIDTH, 4, operand width in bits, unsigned.
REQ-002 Parameter WIDTH_SUM, 8, accumulator and result width in bits; WIDTH_SUM >= 2*WIDTH.
REQ-003 Parameter N, 3, square array dimension (N x N PEs); N >= 2.
REQ-004 CLK  in  1  single clock; all state updates on its rising edge.
REQ-005 RST  in  1  reset, asynchronous, active-low.
REQ-006 ENABLE  in  1  when 0 during COMPUTE, the whole datapath and counter freeze.
REQ-007 START  in  1  request a multiply; sampled only in IDLE.
REQ-008 ACCUM  in  1  sampled with START; 1 = add into existing accumulators, 0 = clear first.
REQ-009 A_FLAT  in  N*N*WIDTH  matrix A, row-major; A[i][k] at bits (i*N+k)*WIDTH +: WIDTH.
REQ-010 B_FLAT  in  N*N*WIDTH  matrix B, row-major; B[k][j] at bits (k*N+j)*WIDTH +: WIDTH.
REQ-011 C_FLAT  out  N*N*WIDTH_SUM  result C, row-major; C[i][j] at bits (i*N+j)*WIDTH_SUM +: WIDTH_SUM.
REQ-012 BUSY  out  1  high in COMPUTE and DONE states.
REQ-013 DONE  out  1  one-cycle pulse when C_FLAT is updated.
REQ-014 C_VALID  out  1  high from DONE until the next accepted START.
REQ-015 MULTI_OVER  out  1  sticky overflow flag, OR over all PEs.

Function
REQ-016 FSM states IDLE, COMPUTE, DONE; IDLE -> COMPUTE on START=1; COMPUTE -> DONE when skew counter t = 3N-3 and ENABLE=1; DONE -> IDLE unconditionally after one cycle.
REQ-017 On the edge accepting START, A_FLAT and B_FLAT are captured into internal registers, t cleared to 0, C_VALID cleared; later input changes have no effect on the run.
REQ-018 START while BUSY=1 is ignored, no state or output change.
REQ-019 Skew feed at step t: row-edge input i = A[i][t-i] if 0 <= t-i < N, else 0; column-edge input j = B[t-j][j] if 0 <= t-j < N, else 0.
REQ-020 PE(i,j) registers its a and b operands and forwards them to PE(i,j+1) and PE(i+1,j) respectively (one cycle per hop); each enabled COMPUTE edge, acc(i,j) += a_in*b_in.
REQ-021 t increments by 1 per COMPUTE edge with ENABLE=1; ENABLE=0 holds t, operand pipeline, and accumulators.
REQ-022 Latency: with ENABLE held 1, DONE is high in the cycle after the (3N-2)th rising edge following the START-accepting edge (N=3: 7 edges).
REQ-023 On COMPUTE -> DONE transition, C_FLAT loads all accumulators; C_FLAT otherwise holds its value, including during COMPUTE.
REQ-024 Arithmetic unsigned; product 2*WIDTH bits zero-extended; accumulation wraps modulo 2^WIDTH_SUM.
REQ-025 MULTI_OVER sets when any accumulation carries out of WIDTH_SUM bits; stays set until START with ACCUM=0 is accepted or reset.
REQ-026 START with ACCUM=0 clears all accumulators, operand pipeline, and MULTI_OVER; ACCUM=1 clears only the operand pipeline.
REQ-027 ENABLE has no effect in IDLE or DONE.

Reset
REQ-028 RST=0 forces, immediately and regardless of CLK: state IDLE, t=0, all PE registers and accumulators 0, C_FLAT=0, BUSY=0, DONE=0, C_VALID=0, MULTI_OVER=0.
REQ-029 Reset mid-COMPUTE abandons the run; no DONE is produced for it.
REQ-030 First START is accepted on the first rising edge after RST returns to 1.

Verification (N=3, WIDTH=4, WIDTH_SUM=8 unless stated)
REQ-031 A=identity, B=[1..9], ACCUM=0 -> C=[1..9], DONE one cycle 7 edges after START, MULTI_OVER=0.
REQ-032 A=B=all 15 -> every C element = 675 mod 256 = 163, MULTI_OVER=1; next run A=identity, ACCUM=0 -> MULTI_OVER=0.
REQ-033 Run REQ-031, then same inputs with ACCUM=1 -> C=[2,4,...,18], C_VALID low during second run, high after DONE.
REQ-034 ENABLE=0 for 2 cycles at t=3 -> DONE at 9 edges, C identical to REQ-031; START pulsed while BUSY -> ignored.
REQ-035 RST=0 at t=4 -> all outputs 0 immediately; subsequent REQ-031 run passes unchanged.
REQ-036 Build N=4: A=all 1, B=all 2 -> every C element = 8, DONE 10 edges after START.
